// File: rtl/dual_rail_pkg.sv
// rtl/dual_rail_pkg.sv - shared types, rail codes and decode helpers for the dual-rail receiver
// Rail pair is {out1,out2}; one-hot codes are legal symbols, 00/11 are line faults.
package dual_rail_pkg;

  typedef enum logic [1:0] {
    ACQ   = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } rx_state_t;

  localparam logic [1:0] SYM0     = 2'b10;
  localparam logic [1:0] SYM1     = 2'b01;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LO   = 2'b01;
  localparam logic [1:0] ERR_HI   = 2'b10;

  function automatic logic code_valid(input logic [1:0] code);
    return (code == SYM0) || (code == SYM1);
  endfunction

  function automatic logic code_level(input logic [1:0] code);
    return (code == SYM1);
  endfunction

  // Only meaningful for illegal codes: both rails low vs both rails high.
  function automatic logic [1:0] fault_code(input logic [1:0] code);
    return (code == 2'b00) ? ERR_LO : ERR_HI;
  endfunction

endpackage

// File: rtl/dual_rail_stab.sv
// rtl/dual_rail_stab.sv - rail sample register with saturating stability counter
// stable asserts once the same code has been seen FILT consecutive samples.
module dual_rail_stab
  import dual_rail_pkg::*;
#(
  parameter int FILT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sample,
  output logic [1:0] code_q,
  output logic       stable
);

  localparam int SW = $clog2(FILT + 1);

  logic [SW-1:0] stab;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_q <= SYM1;
      stab   <= '0;
    end else begin
      code_q <= sample;
      if (sample != code_q) begin
        stab <= SW'(1);
      end else if (stab != SW'(FILT)) begin
        stab <= stab + SW'(1);
      end
    end
  end

  assign stable = (stab == SW'(FILT));

endmodule

// File: rtl/dual_rail_rx.sv
// rtl/dual_rail_rx.sv - dual-rail link receiver: filter, level recovery, edge count, fault trap
// FSM acts on the filtered code; all outputs are registered.
module dual_rail_rx
  import dual_rail_pkg::*;
#(
  parameter int FILT  = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             out1_i,
  input  logic             out2_i,
  input  logic             clr,
  output logic             a_rec,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             err,
  output logic [1:0]       err_code
);

  rx_state_t        state, state_nxt;
  logic [1:0]       code_q;
  logic             stable;
  logic             a_nxt, rise_nxt, fall_nxt, err_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [1:0]       code_nxt;
  logic             valid, level;

  dual_rail_stab #(
    .FILT(FILT)
  ) u_stab (
    .clk   (clk),
    .reset (reset),
    .sample({out1_i, out2_i}),
    .code_q(code_q),
    .stable(stable)
  );

  assign valid = code_valid(code_q);
  assign level = code_level(code_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ACQ;
      a_rec    <= 1'b1;
      rise     <= 1'b0;
      fall     <= 1'b0;
      edge_cnt <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      state    <= state_nxt;
      a_rec    <= a_nxt;
      rise     <= rise_nxt;
      fall     <= fall_nxt;
      edge_cnt <= cnt_nxt;
      err      <= err_nxt;
      err_code <= code_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    a_nxt     = a_rec;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    cnt_nxt   = edge_cnt;
    err_nxt   = err;
    code_nxt  = err_code;
    if (clr) begin
      // clr wins over acquisition, edges and faults in the same cycle.
      state_nxt = ACQ;
      cnt_nxt   = '0;
      err_nxt   = 1'b0;
      code_nxt  = ERR_NONE;
    end else begin
      case (state)
        ACQ: begin
          if (stable && valid) begin
            a_nxt     = level;
            state_nxt = TRACK;
          end else if (stable) begin
            state_nxt = FAULT;
            err_nxt   = 1'b1;
            if (err_code == ERR_NONE) code_nxt = fault_code(code_q);
          end
        end
        TRACK: begin
          if (stable && valid) begin
            if (level != a_rec) begin
              a_nxt    = level;
              rise_nxt = level;
              fall_nxt = ~level;
              cnt_nxt  = edge_cnt + CNT_W'(1);
            end
          end else if (stable) begin
            state_nxt = FAULT;
            err_nxt   = 1'b1;
            if (err_code == ERR_NONE) code_nxt = fault_code(code_q);
          end
        end
        FAULT: begin
        end
        default: state_nxt = ACQ;
      endcase
    end
  end

endmodule

// File: tb/tb_dual_rail_rx.sv
// tb/tb_dual_rail_rx.sv - directed self-checking bench for dual_rail_rx (FILT=2, CNT_W=8)
module tb_dual_rail_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       out1_i, out2_i, clr;
  logic       a_rec, rise, fall, err;
  logic [7:0] edge_cnt;
  logic [1:0] err_code;

  int tests = 0;
  int fails = 0;

  dual_rail_rx #(.FILT(2), .CNT_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .out1_i  (out1_i),
    .out2_i  (out2_i),
    .clr     (clr),
    .a_rec   (a_rec),
    .rise    (rise),
    .fall    (fall),
    .edge_cnt(edge_cnt),
    .err     (err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rails(input logic r1, input logic r2);
    out1_i = r1;
    out2_i = r2;
  endtask

  task automatic test_reset;
    reset = 1'b1; clr = 1'b0; rails(1'b0, 1'b1);
    #2;
    tests++;
    if ({a_rec, rise, fall, edge_cnt, err, err_code} !== {1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 2'b00}) begin
      fails++;
      $display("FAIL reset_values got a=%b r=%b f=%b cnt=%0d err=%b code=%b want a=1 r=0 f=0 cnt=0 err=0 code=00",
               a_rec, rise, fall, edge_cnt, err, err_code);
    end
    step(1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      tests++;
      if ({a_rec, rise, fall, edge_cnt, err} !== {1'b1, 1'b0, 1'b0, 8'd0, 1'b0}) begin
        fails++;
        $display("FAIL acquire_01 cyc%0d got a=%b r=%b f=%b cnt=%0d err=%b want a=1 r=0 f=0 cnt=0 err=0",
                 i, a_rec, rise, fall, edge_cnt, err);
      end
    end
  endtask

  task automatic test_edges;
    rails(1'b1, 1'b0);
    step(2);
    tests++;
    if ({fall, a_rec} !== 2'b01) begin
      fails++; $display("FAIL fall_early got f=%b a=%b want f=0 a=1", fall, a_rec);
    end
    step(1);
    tests++;
    if ({rise, fall, a_rec, edge_cnt} !== {1'b0, 1'b1, 1'b0, 8'd1}) begin
      fails++; $display("FAIL fall_pulse got r=%b f=%b a=%b cnt=%0d want r=0 f=1 a=0 cnt=1", rise, fall, a_rec, edge_cnt);
    end
    step(1);
    tests++;
    if (fall !== 1'b0) begin
      fails++; $display("FAIL fall_one_cycle got f=%b want 0", fall);
    end
    step(1);
    rails(1'b0, 1'b1);
    step(2);
    tests++;
    if (rise !== 1'b0) begin
      fails++; $display("FAIL rise_early got r=%b want 0", rise);
    end
    step(1);
    tests++;
    if ({rise, fall, a_rec, edge_cnt} !== {1'b1, 1'b0, 1'b1, 8'd2}) begin
      fails++; $display("FAIL rise_pulse got r=%b f=%b a=%b cnt=%0d want r=1 f=0 a=1 cnt=2", rise, fall, a_rec, edge_cnt);
    end
    step(1);
    tests++;
    if (rise !== 1'b0) begin
      fails++; $display("FAIL rise_one_cycle got r=%b want 0", rise);
    end
  endtask

  task automatic test_glitch;
    rails(1'b1, 1'b0);
    step(1);
    rails(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1);
      tests++;
      if ({rise, fall, a_rec, edge_cnt} !== {1'b0, 1'b0, 1'b1, 8'd2}) begin
        fails++;
        $display("FAIL glitch cyc%0d got r=%b f=%b a=%b cnt=%0d want r=0 f=0 a=1 cnt=2", i, rise, fall, a_rec, edge_cnt);
      end
    end
  endtask

  task automatic test_fault;
    rails(1'b1, 1'b1);
    step(2);
    tests++;
    if (err !== 1'b0) begin
      fails++; $display("FAIL fault_early got err=%b want 0", err);
    end
    step(1);
    tests++;
    if ({err, err_code, rise, fall} !== {1'b1, 2'b10, 1'b0, 1'b0}) begin
      fails++; $display("FAIL fault_11 got err=%b code=%b r=%b f=%b want err=1 code=10 r=0 f=0", err, err_code, rise, fall);
    end
    rails(1'b0, 1'b0);
    step(4);
    tests++;
    if ({err, err_code, a_rec, edge_cnt} !== {1'b1, 2'b10, 1'b1, 8'd2}) begin
      fails++; $display("FAIL fault_first_kept got err=%b code=%b a=%b cnt=%0d want err=1 code=10 a=1 cnt=2",
                        err, err_code, a_rec, edge_cnt);
    end
    rails(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      tests++;
      if ({rise, fall, a_rec, edge_cnt, err} !== {1'b0, 1'b0, 1'b1, 8'd2, 1'b1}) begin
        fails++; $display("FAIL fault_hold cyc%0d got r=%b f=%b a=%b cnt=%0d err=%b want r=0 f=0 a=1 cnt=2 err=1",
                          i, rise, fall, a_rec, edge_cnt, err);
      end
    end
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    tests++;
    if ({err, err_code, edge_cnt, a_rec, fall} !== {1'b0, 2'b00, 8'd0, 1'b1, 1'b0}) begin
      fails++; $display("FAIL fault_clr got err=%b code=%b cnt=%0d a=%b f=%b want err=0 code=00 cnt=0 a=1 f=0",
                        err, err_code, edge_cnt, a_rec, fall);
    end
    step(1);
    tests++;
    if ({a_rec, rise, fall, edge_cnt, err} !== {1'b0, 1'b0, 1'b0, 8'd0, 1'b0}) begin
      fails++; $display("FAIL reacquire got a=%b r=%b f=%b cnt=%0d err=%b want a=0 r=0 f=0 cnt=0 err=0",
                        a_rec, rise, fall, edge_cnt, err);
    end
  endtask

  task automatic test_wrap;
    logic       lvl;
    logic [7:0] exp_cnt;
    lvl = 1'b0;
    exp_cnt = 8'd0;
    for (int i = 0; i < 256; i++) begin
      lvl = ~lvl;
      rails(~lvl, lvl);
      step(3);
      exp_cnt = exp_cnt + 8'd1;
      tests++;
      if ({rise, fall, a_rec, edge_cnt} !== {lvl, ~lvl, lvl, exp_cnt}) begin
        fails++; $display("FAIL toggle%0d got r=%b f=%b a=%b cnt=%0d want r=%b f=%b a=%b cnt=%0d",
                          i, rise, fall, a_rec, edge_cnt, lvl, ~lvl, lvl, exp_cnt);
      end
    end
    tests++;
    if (edge_cnt !== 8'd0) begin
      fails++; $display("FAIL wrap got cnt=%0d want 0", edge_cnt);
    end
    rails(1'b0, 1'b1);
    step(2);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    tests++;
    if ({rise, fall, edge_cnt, a_rec} !== {1'b0, 1'b0, 8'd0, 1'b0}) begin
      fails++; $display("FAIL clr_on_pulse got r=%b f=%b cnt=%0d a=%b want r=0 f=0 cnt=0 a=0", rise, fall, edge_cnt, a_rec);
    end
    step(1);
    tests++;
    if ({rise, fall, edge_cnt, a_rec} !== {1'b0, 1'b0, 8'd0, 1'b1}) begin
      fails++; $display("FAIL clr_reacquire got r=%b f=%b cnt=%0d a=%b want r=0 f=0 cnt=0 a=1", rise, fall, edge_cnt, a_rec);
    end
  endtask

  task automatic test_async_reset;
    rails(1'b1, 1'b0);
    step(3);
    tests++;
    if ({a_rec, fall, edge_cnt} !== {1'b0, 1'b1, 8'd1}) begin
      fails++; $display("FAIL pre_reset got a=%b f=%b cnt=%0d want a=0 f=1 cnt=1", a_rec, fall, edge_cnt);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({a_rec, rise, fall, edge_cnt, err, err_code} !== {1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 2'b00}) begin
      fails++; $display("FAIL async_reset got a=%b r=%b f=%b cnt=%0d err=%b code=%b want a=1 r=0 f=0 cnt=0 err=0 code=00",
                        a_rec, rise, fall, edge_cnt, err, err_code);
    end
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_edges();
    test_glitch();
    test_fault();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
